// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ITER = 32;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // True for the four iterative operations.
   function automatic logic isMulDivFunct(input logic [5:0] funct);
      return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
             (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
   endfunction

   // True for the two direct HI/LO writes.
   function automatic logic isMoveFunct(input logic [5:0] funct);
      return (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO);
   endfunction

   // Two's-complement negation of a 32-bit value.
   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
      return XLEN'(~x + XLEN'(1));
   endfunction

   // Two's-complement negation of a 64-bit value.
   function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] x);
      return (2*XLEN)'(~x + (2*XLEN)'(1));
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes.
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic                isDiv,
   input  logic [XLEN-1:0]     opA,
   input  logic [XLEN-1:0]     opB,
   output logic [2*XLEN-1:0]   result
);

   // acc = {upper half (partial product / remainder), lower half (multiplier / quotient)}
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] accNext;
   logic [XLEN-1:0]   opBReg;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     rem;
   logic [XLEN:0]     diff;

   // One iteration: conditional add-and-shift-right, or shift-left-and-trial-subtract.
   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opBReg};
      rem     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = rem - {1'b0, opBReg};
      accNext = acc;
      if (isDiv) begin
         if (!diff[XLEN]) begin
            accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            accNext = {rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end else begin
         if (acc[0]) begin
            accNext = {sum, acc[XLEN-1:1]};
         end else begin
            accNext = {1'b0, acc[2*XLEN-1:1]};
         end
      end
   end

   // Accumulator and second-operand register.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         opBReg <= '0;
      end else if (load) begin
         acc    <= {{XLEN{1'b0}}, opA};
         opBReg <= opB;
      end else if (step) begin
         acc    <= accNext;
      end
   end

   assign result = acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide controller: FSM, iteration counter, sign fix-up, HI/LO and pipeline stall.
module muldiv_sequencer #(
   parameter int unsigned ITER = muldiv_pkg::ITER
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        Start,
   input  logic [5:0]                  ALUFunction,
   input  logic [muldiv_pkg::XLEN-1:0] RsData,
   input  logic [muldiv_pkg::XLEN-1:0] RtData,
   input  logic                        MFRead,
   output logic                        Stall,
   output logic                        Busy,
   output logic                        Done,
   output logic [muldiv_pkg::XLEN-1:0] HI,
   output logic [muldiv_pkg::XLEN-1:0] LO
);
   import muldiv_pkg::*;

   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

   state_t              state;
   state_t              stateNext;
   logic [CNT_W-1:0]    count;
   logic                load;
   logic                step;

   logic                opIsDiv;
   logic                negLo;
   logic                negHi;
   logic                divZero;

   logic                functMulDiv;
   logic                functMove;
   logic                acceptMulDiv;
   logic                signedOp;
   logic                rsNeg;
   logic                rtNeg;
   logic [XLEN-1:0]     magA;
   logic [XLEN-1:0]     magB;
   logic [2*XLEN-1:0]   raw;
   logic [2*XLEN-1:0]   product;
   logic [XLEN-1:0]     quot;
   logic [XLEN-1:0]     remd;

   // Decode the presented instruction and form operand magnitudes.
   always_comb begin
      functMulDiv  = isMulDivFunct(ALUFunction);
      functMove    = isMoveFunct(ALUFunction);
      acceptMulDiv = Start & functMulDiv;
      signedOp     = ~ALUFunction[0];
      rsNeg        = signedOp & RsData[XLEN-1];
      rtNeg        = signedOp & RtData[XLEN-1];
      magA         = rsNeg ? neg32(RsData) : RsData;
      magB         = rtNeg ? neg32(RtData) : RtData;
   end

   // Next state and datapath control.
   always_comb begin
      stateNext = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (acceptMulDiv) begin
               stateNext = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == CNT_W'(ITER - 1)) begin
               stateNext = FIX;
            end
         end
         FIX: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Iteration counter and per-operation sign/kind flags captured at acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         opIsDiv <= 1'b0;
         negLo   <= 1'b0;
         negHi   <= 1'b0;
         divZero <= 1'b0;
      end else if (load) begin
         count   <= '0;
         opIsDiv <= ALUFunction[1];
         negLo   <= rsNeg ^ rtNeg;
         negHi   <= ALUFunction[1] ? rsNeg : (rsNeg ^ rtNeg);
         divZero <= ALUFunction[1] & (RtData == '0);
      end else if (step) begin
         count   <= count + CNT_W'(1);
      end
   end

   muldiv_datapath uDatapath (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .isDiv  (opIsDiv),
      .opA    (magA),
      .opB    (magB),
      .result (raw)
   );

   // Signed fix-up of the magnitude result; divide-by-zero forces an all-ones quotient.
   always_comb begin
      product = negLo ? neg64(raw) : raw;
      quot    = divZero ? '1 : (negLo ? neg32(raw[XLEN-1:0]) : raw[XLEN-1:0]);
      remd    = negHi ? neg32(raw[2*XLEN-1:XLEN]) : raw[2*XLEN-1:XLEN];
   end

   // HI/LO: written by the FIX edge or by an accepted MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (reset) begin
         HI <= '0;
         LO <= '0;
      end else if (state == FIX) begin
         if (opIsDiv) begin
            HI <= remd;
            LO <= quot;
         end else begin
            HI <= product[2*XLEN-1:XLEN];
            LO <= product[XLEN-1:0];
         end
      end else if ((state == IDLE) && Start) begin
         if (ALUFunction == FUNCT_MTHI) begin
            HI <= RsData;
         end
         if (ALUFunction == FUNCT_MTLO) begin
            LO <= RsData;
         end
      end
   end

   // Status decoded from state; stall is combinational so the held instruction retries in IDLE.
   assign Busy  = (state != IDLE);
   assign Done  = (state == FIX);
   assign Stall = Busy & (MFRead | (Start & (functMulDiv | functMove)));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [5:0]  ALUFunction;
   logic [31:0] RsData;
   logic [31:0] RtData;
   logic        MFRead;
   logic        Stall;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.ITER(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .Start       (Start),
      .ALUFunction (ALUFunction),
      .RsData      (RsData),
      .RtData      (RtData),
      .MFRead      (MFRead),
      .Stall       (Stall),
      .Busy        (Busy),
      .Done        (Done),
      .HI          (HI),
      .LO          (LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait until Done is seen; returns cycles counted from the Start cycle (Start cycle = 0).
   task automatic waitDone(inout int cycles);
      while (!Done && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   // Issue one mult/div from IDLE and check latency, Done pulse and HI/LO.
   task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
      int cycles;
      Start = 1'b1; ALUFunction = f; RsData = a; RtData = b;
      #1;
      check({tag, "_stall_idle"}, 32'(Stall), 32'd0);
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      cycles = 1;
      waitDone(cycles);
      check({tag, "_latency"}, 32'(cycles), 32'd33);
      tick();
      check({tag, "_done_pulse"}, 32'(Done), 32'd0);
      check({tag, "_busy_after"}, 32'(Busy), 32'd0);
      check({tag, "_hi"}, HI, expHi);
      check({tag, "_lo"}, LO, expLo);
   endtask

   initial begin
      int  cycles;
      logic stallAll;

      reset = 1'b1; Start = 1'b0; ALUFunction = 6'h00;
      RsData = '0; RtData = '0; MFRead = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);

      // MTHI then MTLO back-to-back
      Start = 1'b1; ALUFunction = 6'h11; RsData = 32'h1234;
      #1;
      check("mthi_stall", 32'(Stall), 32'd0);
      tick();
      ALUFunction = 6'h13; RsData = 32'h5678;
      #1;
      check("mtlo_stall", 32'(Stall), 32'd0);
      check("mthi_hi", HI, 32'h1234);
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      check("mt_hi", HI, 32'h1234);
      check("mt_lo", LO, 32'h5678);
      check("mt_busy", 32'(Busy), 32'd0);

      // Unrecognised funct is ignored
      Start = 1'b1; ALUFunction = 6'h20; RsData = 32'hDEAD; RtData = 32'h1;
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      check("ignore_busy", 32'(Busy), 32'd0);
      check("ignore_hi", HI, 32'h1234);

      runOp("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      runOp("mult_neg",  6'h18, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      runOp("div_neg",   6'h1A, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("divu_zero", 6'h1B, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      runOp("div_ovf",   6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      runOp("divu_basic",6'h1B, 32'd1000,      32'd7,         32'd6,         32'd142);

      // MFLO three cycles after a MULT stalls until Done, then sees the product
      Start = 1'b1; ALUFunction = 6'h18; RsData = 32'd6; RtData = 32'd7;
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      tick(); tick();
      MFRead = 1'b1;
      #1;
      check("mflo_stall_on", 32'(Stall), 32'd1);
      cycles = 3;
      stallAll = 1'b1;
      while (!Done && cycles < 100) begin
         tick();
         cycles++;
         stallAll = stallAll & Stall;
      end
      check("mflo_seen_done", 32'(Done), 32'd1);
      check("mflo_stall_held", 32'(stallAll), 32'd1);
      tick();
      check("mflo_stall_off", 32'(Stall), 32'd0);
      check("mflo_lo", LO, 32'd42);
      check("mflo_hi", HI, 32'd0);
      MFRead = 1'b0;

      // Second DIV presented mid-RUN is stalled, then accepted in IDLE
      Start = 1'b1; ALUFunction = 6'h18; RsData = 32'd5; RtData = 32'd5;
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      tick(); tick(); tick(); tick();
      Start = 1'b1; ALUFunction = 6'h1A; RsData = 32'd20; RtData = 32'd3;
      #1;
      check("div2_stall_on", 32'(Stall), 32'd1);
      cycles = 0;
      while (Stall && cycles < 100) begin
         tick();
         cycles++;
      end
      check("div2_stall_released", 32'(Stall), 32'd0);
      check("div2_idle", 32'(Busy), 32'd0);
      check("mult25_lo", LO, 32'd25);
      check("mult25_hi", HI, 32'd0);
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      check("div2_accepted", 32'(Busy), 32'd1);
      cycles = 1;
      waitDone(cycles);
      check("div2_latency", 32'(cycles), 32'd33);
      tick();
      check("div2_lo", LO, 32'd6);
      check("div2_hi", HI, 32'd2);

      // Reset at RUN counter 15 discards the operation
      Start = 1'b1; ALUFunction = 6'h19; RsData = 32'h1234_5678; RtData = 32'h9;
      tick();
      Start = 1'b0; ALUFunction = 6'h00;
      for (int i = 0; i < 15; i++) tick();
      check("pre_rst_busy", 32'(Busy), 32'd1);
      reset = 1'b1; MFRead = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_stall", 32'(Stall), 32'd0);
      check("midrst_done", 32'(Done), 32'd0);
      check("midrst_hi", HI, 32'h0);
      check("midrst_lo", LO, 32'h0);
      MFRead = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("midrst_no_done_hi", HI, 32'h0);
      check("midrst_no_done_lo", LO, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
